mod_storedata: RTL and testbench
================================

Name: mod_storedata

Overview:
- Store-side counterpart of the load writeback formatter in the RV32I core.
- Takes store requests (SB/SH/SW) from the execute stage and aligns data to the 32-bit word lane. It also generates byte enables and detects misaligned or illegal stores.
- Queues formatted writes in a small in-order buffer and drains them to data memory over a req/ack handshake.
- The load path uses `empty` to stall loads until all pending stores have drained.

Parameters:
- DEPTH, 2, number of buffered store entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- st_valid  in  1  execute stage presents a store.
- st_ready  out  1  block can accept a store this cycle.
- st_addr  in  32  byte address of the store.
- st_data  in  32  rs2 value; the low bits are used for SB and SH.
- st_funct3  in  3  000 = SB, 001 = SH, 010 = SW; all other codes are illegal.
- mem_req  out  1  head entry is valid and presented to memory.
- mem_addr  out  32  word-aligned address: {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables; bit i enables byte i (little-endian).
- mem_ack  in  1  memory accepts the head entry this cycle.
- st_err  out  1  one-cycle pulse: the previous accepted store was misaligned or illegal.
- st_err_addr  out  32  st_addr of the faulting store; held until the next error.
- empty  out  1  buffer holds no entries.

Behaviour:
- Reset, synchronous and active-high:
  - Pointers and count cleared.
  - mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - st_err=0, st_err_addr=0, empty=1.
  - Any in-flight memory request is abandoned.
- st_ready = !rst && (count != DEPTH). It depends on registered count only; there is no combinational path from mem_ack to st_ready.
- Handshake on the store side: a store is accepted when st_valid && st_ready. Accepted stores complete the handshake whether legal or not.
- Formatting, purely from st_addr[1:0] and st_funct3:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: requires addr[0]=0. be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - SW: requires addr[1:0]=00. be = 4'b1111; wdata = data.
- Faults (misaligned SH/SW, or illegal funct3):
  - The store is not enqueued.
  - st_err=1 on the next cycle, and st_err_addr is loaded with st_addr.
  - mem_req is unaffected.
- Buffer: FIFO of {word addr, wdata, be} with DEPTH entries. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Memory side:
  - mem_req = (count != 0).
  - mem_addr, mem_wdata and mem_be show the head entry and are driven from registers.
  - All four stay stable while mem_req=1 and mem_ack=0.
- Pop: on mem_req && mem_ack, the head advances. mem_ack while mem_req=0 is ignored.
- Latency: a store accepted at edge N into an empty buffer gives mem_req=1 in cycle N+1. Back-to-back acks drain one entry per cycle.
- Simultaneous push and pop (0 < count < DEPTH): both take effect and count is unchanged. When full, no push occurs, because st_ready=0.
- Ordering: strictly in acceptance order. No merging, no reordering.
- empty = (count == 0), registered-equivalent. It deasserts the cycle after the first accept.
- Reset mid-operation: buffered entries are discarded. An ack arriving in the cycle after reset is ignored, since mem_req=0.

Test Plan:
- SB, addr=0x0000_0103, data=0x1234_5678, ack held 1 -> next cycle: mem_req=1, mem_addr=0x100, mem_be=4'b1000, mem_wdata=0x7878_7878. Then empty=1 one cycle after the ack.
- SH, addr=0x0000_0202, data=0xFFFF_ABCD -> mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xABCD_ABCD. SW at 0x204 with data=0xDEAD_BEEF -> be=4'b1111, wdata=0xDEAD_BEEF.
- SW at 0x101, then funct3=3'b011 at 0x108 -> st_err pulses on the cycle after each, with st_err_addr=0x101 then 0x108. mem_req stays 0 and empty stays 1.
- DEPTH=2, mem_ack=0, three SW stores back-to-back (0x10, 0x14, 0x18) -> st_ready=0 after two accepts and the third is held. Raise ack -> mem writes occur in order 0x10, 0x14, 0x18, and the head outputs stay stable while ack=0.
- count=1 with mem_ack=1 and a new store accepted in the same cycle -> count stays 1, the new entry becomes head next cycle, and mem_req stays high.
- Two entries pending, rst=1 for one cycle with mem_ack=1 -> after reset: mem_req=0, empty=1, st_ready=1, and no write completes.

Source files
------------

// File: rtl/mod_storedata.sv
`default_nettype none
// ============================================================================
// mod_storedata : RV32I store formatter + in-order write buffer (req/ack drain)
// Rev 1.0
// ============================================================================
module mod_storedata #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        st_err,
  output logic [31:0] st_err_addr,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 30 + 32 + 4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             st_err_q, st_err_d;
  logic [31:0]      st_err_addr_q, st_err_addr_d;
  logic [ENT_W-1:0] entry_q [DEPTH];
  logic [ENT_W-1:0] entry_d [DEPTH];

  logic             w_accept;
  logic             w_legal;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [ENT_W-1:0] w_new_entry;
  logic [ENT_W-1:0] w_head;

  assign st_ready = !rst && (count_q != CNT_FULL);
  assign w_accept = st_valid && st_ready;

  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (st_funct3)
      F3_SB: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << st_addr[1:0];
        w_wdata = {4{st_data[7:0]}};
      end
      F3_SH: begin
        w_legal = !st_addr[0];
        w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{st_data[15:0]}};
      end
      F3_SW: begin
        w_legal = (st_addr[1:0] == 2'b00);
        w_be    = 4'b1111;
        w_wdata = st_data;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_push      = w_accept && w_legal;
  assign w_pop       = mem_req && mem_ack;
  assign w_new_entry = {st_addr[31:2], w_wdata, w_be};

  always_comb begin
    wr_ptr_d      = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d       = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!w_push && w_pop) begin
      count_d = count_q - CNT_ONE;
    end
    // Faulting stores complete the handshake but only raise the error pulse.
    st_err_d      = w_accept && !w_legal;
    st_err_addr_d = st_err_d ? st_addr : st_err_addr_q;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_comb begin
      entry_d[i] = (w_push && (wr_ptr_q == PTR_W'(i))) ? w_new_entry : entry_q[i];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        entry_q[i] <= '0;
      end else begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      st_err_q      <= 1'b0;
      st_err_addr_q <= 32'h0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      st_err_q      <= st_err_d;
      st_err_addr_q <= st_err_addr_d;
    end
  end

  // Head fields read straight from entry flops; zeroed when nothing is pending.
  assign w_head      = entry_q[rd_ptr_q];
  assign mem_req     = (count_q != '0);
  assign mem_addr    = mem_req ? {w_head[ENT_W-1:36], 2'b00} : 32'h0;
  assign mem_wdata   = mem_req ? w_head[35:4] : 32'h0;
  assign mem_be      = mem_req ? w_head[3:0] : 4'b0000;
  assign empty       = (count_q == '0);
  assign st_err      = st_err_q;
  assign st_err_addr = st_err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_storedata.sv
`default_nettype none
// ============================================================================
// tb_mod_storedata : directed + random bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_mod_storedata;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic [2:0]  st_funct3 = 3'b000;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        st_err;
  logic [31:0] st_err_addr;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t      q[$];
  logic        m_err      = 1'b0;
  logic [31:0] m_err_addr = 32'h0;

  always #5 clk = ~clk;

  mod_storedata #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_funct3   (st_funct3),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .st_err      (st_err),
    .st_err_addr (st_err_addr),
    .empty       (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Store size in bytes; each written byte lane i takes source byte (i mod size).
  function automatic void fmt(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                              output bit ok, output logic [31:0] wd, output logic [3:0] be);
    int size;
    int off;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    off  = int'(a % 4);
    ok   = (size != 0) && ((a % size) == 0);
    wd   = 32'h0;
    be   = 4'h0;
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        be[i]        = (i >= off) && (i < off + size);
        wd[8*i +: 8] = d[8*(i % size) +: 8];
      end
    end
  endfunction

  task automatic cycle();
    bit          ready, accept, ok;
    logic [31:0] wd;
    logic [3:0]  be;
    entry_t      e;
    #1;
    ready = !rst && (q.size() < DEPTH);
    chk("st_ready", st_ready, ready);
    accept = st_valid && ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_err      = 1'b0;
      m_err_addr = 32'h0;
    end else begin
      if (q.size() != 0 && mem_ack) void'(q.pop_front());
      m_err = 1'b0;
      if (accept) begin
        fmt(st_funct3, st_addr, st_data, ok, wd, be);
        if (ok) begin
          e.addr  = {st_addr[31:2], 2'b00};
          e.wdata = wd;
          e.be    = be;
          q.push_back(e);
        end else begin
          m_err      = 1'b1;
          m_err_addr = st_addr;
        end
      end
    end
    #1;
    chk("mem_req", mem_req, q.size() != 0);
    chk("empty", empty, q.size() == 0);
    chk("st_err", st_err, m_err);
    chk("st_err_addr", st_err_addr, m_err_addr);
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_wdata", mem_wdata, q[0].wdata);
      chk("mem_be", mem_be, 32'(q[0].be));
    end else begin
      chk("mem_addr_idle", mem_addr, 32'h0);
      chk("mem_wdata_idle", mem_wdata, 32'h0);
      chk("mem_be_idle", mem_be, 32'h0);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic ack, input logic r);
    @(negedge clk);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f;
    mem_ack   = ack;
    rst       = r;
    cycle();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);

    drive(1, 32'h0000_0103, 32'h1234_5678, 3'b000, 1, 0);
    chk("sb_addr", mem_addr, 32'h0000_0100);
    chk("sb_be", mem_be, 32'h8);
    chk("sb_wdata", mem_wdata, 32'h7878_7878);
    drive(0, 0, 0, 0, 1, 0);
    chk("sb_drained", empty, 1);

    drive(1, 32'h0000_0202, 32'hFFFF_ABCD, 3'b001, 0, 0);
    chk("sh_be", mem_be, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 32'h0000_0204, 32'hDEAD_BEEF, 3'b010, 0, 0);
    chk("sw_be", mem_be, 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    drive(0, 0, 0, 0, 1, 0);

    drive(1, 32'h0000_0101, 32'h1111_1111, 3'b010, 0, 0);
    chk("err_sw", st_err_addr, 32'h0000_0101);
    drive(1, 32'h0000_0108, 32'h2222_2222, 3'b011, 0, 0);
    chk("err_f3", st_err_addr, 32'h0000_0108);
    drive(0, 0, 0, 0, 0, 0);

    drive(1, 32'h10, 32'hA0A0_0010, 3'b010, 0, 0);
    drive(1, 32'h14, 32'hA0A0_0014, 3'b010, 0, 0);
    drive(1, 32'h18, 32'hA0A0_0018, 3'b010, 0, 0);
    drive(1, 32'h18, 32'hA0A0_0018, 3'b010, 0, 0);
    chk("full_head", mem_addr, 32'h10);
    drive(1, 32'h18, 32'hA0A0_0018, 3'b010, 1, 0);
    chk("pop1_head", mem_addr, 32'h14);
    drive(1, 32'h18, 32'hA0A0_0018, 3'b010, 1, 0);
    chk("pushpop_head", mem_addr, 32'h18);
    drive(0, 0, 0, 0, 1, 0);

    drive(1, 32'h40, 32'h0, 3'b010, 0, 0);
    drive(1, 32'h44, 32'h0, 3'b010, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    chk("rst_req", mem_req, 0);
    drive(0, 0, 0, 0, 1, 0);

    for (int n = 0; n < 500; n++) begin
      logic [2:0] f;
      f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, f,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
